// File: rtl/mips_wb_pkg.sv
// Shared load-kind encoding, default widths and reset PC for the MIPS writeback stage.
package mips_wb_pkg;

    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned AW_DEF   = 5;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } ld_type_e;

endpackage

// File: rtl/mips_wb_if.sv
// MEM->WB bundle: MEM-stage result and pipeline control in, GPR write port and W status out.
interface mips_wb_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 32
);

    logic             valid_m;
    logic [31:0]      instr_m;
    logic [DW-1:0]    pc_m;
    logic             wr_m;
    logic [AW-1:0]    waddr_m;
    logic [DW-1:0]    alu_m;
    logic [DW-1:0]    dmem_rd;
    logic             mem_to_reg;
    logic             link_m;
    logic [2:0]       ld_type_m;
    logic             stall_w;
    logic             flush_w;

    logic             gpr_wr;
    logic [AW-1:0]    gpr_waddr;
    logic [DW-1:0]    gpr_wd;
    logic [31:0]      instr_w;
    logic [DW-1:0]    pc_w;
    logic             fwd_valid;
    logic             misalign_w;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output valid_m, instr_m, pc_m, wr_m, waddr_m, alu_m, dmem_rd,
               mem_to_reg, link_m, ld_type_m, stall_w, flush_w,
        input  gpr_wr, gpr_waddr, gpr_wd, instr_w, pc_w, fwd_valid, misalign_w, retire_cnt
    );

    modport slave (
        input  valid_m, instr_m, pc_m, wr_m, waddr_m, alu_m, dmem_rd,
               mem_to_reg, link_m, ld_type_m, stall_w, flush_w,
        output gpr_wr, gpr_waddr, gpr_wd, instr_w, pc_w, fwd_valid, misalign_w, retire_cnt
    );

endinterface

// File: rtl/mips_load_ext.sv
// Load data extraction: picks the big-endian byte/half lane from the read word and extends it.
module mips_load_ext
    import mips_wb_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    off,
    input  ld_type_e      ld_type,
    output logic [DW-1:0] data,
    output logic          misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane 0 is the most significant byte of the word.
    always_comb begin
        byte_sel = rdata[31:24];
        unique case (off)
            2'd0: byte_sel = rdata[31:24];
            2'd1: byte_sel = rdata[23:16];
            2'd2: byte_sel = rdata[15:8];
            2'd3: byte_sel = rdata[7:0];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (ld_type)
            LD_LW: begin
                data       = rdata;
                misaligned = (off != 2'd0);
            end
            LD_LB:   data = {{(DW-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {{(DW-8){1'b0}}, byte_sel};
            LD_LH: begin
                data       = {{(DW-16){half_sel[15]}}, half_sel};
                misaligned = off[0];
            end
            LD_LHU: begin
                data       = {{(DW-16){1'b0}}, half_sel};
                misaligned = off[0];
            end
            default: begin
                data       = rdata;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_wb_stage.sv
// MEM/WB pipeline register plus writeback datapath: load extension, GPR write-data select,
// single-shot write/retire per instruction and a retired-instruction counter.
module mips_wb_stage
    import mips_wb_pkg::*;
#(
    parameter int unsigned   DW       = DW_DEF,
    parameter int unsigned   AW       = AW_DEF,
    parameter logic [DW-1:0] RESET_PC = DW'(mips_wb_pkg::RESET_PC),
    parameter int unsigned   CNT_W    = 32
) (
    input  logic     clk,
    input  logic     rst,
    mips_wb_if.slave bus
);

    logic             valid_q;
    logic             fresh_q;
    logic [31:0]      instr_q;
    logic [DW-1:0]    pc_q;
    logic             wr_q;
    logic [AW-1:0]    waddr_q;
    logic [DW-1:0]    alu_q;
    logic [DW-1:0]    rdata_q;
    logic             mem_to_reg_q;
    logic             link_q;
    logic [2:0]       ld_type_q;
    logic [CNT_W-1:0] cnt_q;

    logic             live;
    logic             misaligned;
    logic             misalign;
    logic [DW-1:0]    load_data;

    // Priority flush > stall > capture. A stalled instruction loses fresh so it writes once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            fresh_q      <= 1'b0;
            instr_q      <= '0;
            pc_q         <= RESET_PC;
            wr_q         <= 1'b0;
            waddr_q      <= '0;
            alu_q        <= '0;
            rdata_q      <= '0;
            mem_to_reg_q <= 1'b0;
            link_q       <= 1'b0;
            ld_type_q    <= '0;
        end else if (bus.flush_w) begin
            valid_q <= 1'b0;
            fresh_q <= 1'b0;
            instr_q <= '0;
        end else if (bus.stall_w) begin
            fresh_q <= 1'b0;
        end else begin
            valid_q      <= bus.valid_m;
            fresh_q      <= bus.valid_m;
            instr_q      <= bus.instr_m;
            pc_q         <= bus.pc_m;
            wr_q         <= bus.wr_m;
            waddr_q      <= bus.waddr_m;
            alu_q        <= bus.alu_m;
            rdata_q      <= bus.dmem_rd;
            mem_to_reg_q <= bus.mem_to_reg;
            link_q       <= bus.link_m;
            ld_type_q    <= bus.ld_type_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (live) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    mips_load_ext #(
        .DW (DW)
    ) u_load_ext (
        .rdata      (rdata_q),
        .off        (alu_q[1:0]),
        .ld_type    (ld_type_e'(ld_type_q)),
        .data       (load_data),
        .misaligned (misaligned)
    );

    assign live     = valid_q & fresh_q;
    assign misalign = live & mem_to_reg_q & misaligned;

    always_comb begin
        bus.gpr_wr    = live & wr_q & (waddr_q != '0) & ~misalign;
        bus.gpr_waddr = waddr_q;
        if (link_q) begin
            bus.gpr_wd = pc_q + DW'(8);
        end else if (mem_to_reg_q) begin
            bus.gpr_wd = load_data;
        end else begin
            bus.gpr_wd = alu_q;
        end
        bus.instr_w    = instr_q;
        bus.pc_w       = pc_q;
        bus.fwd_valid  = bus.gpr_wr;
        bus.misalign_w = misalign;
        bus.retire_cnt = cnt_q;
    end

endmodule

// File: tb/tb_mips_wb_stage.sv
// Randomized bench for mips_wb_stage: behavioural W-slot model checked every cycle plus
// directed literal cases for loads, links, stalls, flush, reset and counter wrap.
module tb_mips_wb_stage;
    import mips_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mips_wb_if #(.DW(32), .AW(5), .CNT_W(32)) bus ();

    mips_wb_stage #(
        .DW       (32),
        .AW       (5),
        .RESET_PC (32'h0000_3000),
        .CNT_W    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one slot describing the instruction sitting in W.
    typedef struct {
        bit          valid;
        bit          fresh;
        bit          wr;
        bit          m2r;
        bit          link;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  wa;
        logic [2:0]  ld;
    } slot_t;

    slot_t       w;
    logic [31:0] retired;
    logic [31:0] cnt_off = 32'd0;

    function automatic slot_t reset_slot();
        slot_t s;
        s = '{valid: 0, fresh: 0, wr: 0, m2r: 0, link: 0, instr: 0, pc: 32'h3000,
              alu: 0, rd: 0, wa: 0, ld: 0};
        return s;
    endfunction

    function automatic logic [31:0] ld_val(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] kind, output bit mis);
        int unsigned b;
        int unsigned h;
        logic [31:0] r;
        mis = 1'b0;
        b = (word >> (24 - 8 * int'(off))) & 32'hFF;
        h = (word >> (off[1] ? 0 : 16)) & 32'hFFFF;
        case (kind)
            3'd0: begin r = word; mis = (off != 2'd0); end
            3'd1: begin r = b; if (b > 127) r = r - 32'd256; end
            3'd2: r = b;
            3'd3: begin r = h; if (h > 32767) r = r - 32'd65536; mis = off[0]; end
            3'd4: begin r = h; mis = off[0]; end
            default: r = word;
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            w       <= reset_slot();
            retired <= 32'd0;
        end else begin
            if (w.valid && w.fresh) retired <= retired + 32'd1;
            if (bus.flush_w) begin
                w.valid <= 1'b0;
                w.fresh <= 1'b0;
                w.instr <= 32'd0;
            end else if (bus.stall_w) begin
                w.fresh <= 1'b0;
            end else begin
                w <= '{valid: bus.valid_m, fresh: bus.valid_m, wr: bus.wr_m,
                       m2r: bus.mem_to_reg, link: bus.link_m, instr: bus.instr_m,
                       pc: bus.pc_m, alu: bus.alu_m, rd: bus.dmem_rd, wa: bus.waddr_m,
                       ld: bus.ld_type_m};
            end
        end
    end

    always @(negedge clk) begin
        bit          mis;
        bit          e_mis;
        bit          e_wr;
        logic [31:0] e_wd;
        logic [31:0] ld;
        if (!rst) begin
            ld    = ld_val(w.rd, w.alu[1:0], w.ld, mis);
            e_mis = w.valid && w.fresh && w.m2r && mis;
            e_wr  = w.valid && w.fresh && w.wr && (w.wa != 5'd0) && !e_mis;
            e_wd  = w.link ? w.pc + 32'd8 : (w.m2r ? ld : w.alu);
            chk("gpr_wr", 32'(bus.gpr_wr), 32'(e_wr));
            chk("fwd_valid", 32'(bus.fwd_valid), 32'(e_wr));
            chk("misalign_w", 32'(bus.misalign_w), 32'(e_mis));
            chk("instr_w", bus.instr_w, w.instr);
            chk("pc_w", bus.pc_w, w.pc);
            chk("retire_cnt", bus.retire_cnt, retired + cnt_off);
            if (e_wr) begin
                chk("gpr_waddr", 32'(bus.gpr_waddr), 32'(w.wa));
                chk("gpr_wd", bus.gpr_wd, e_wd);
            end
        end
    end

    // Called at a negedge; drives MEM inputs and returns at the next negedge.
    task automatic op(input bit v, input logic [31:0] pc, input bit wr, input logic [4:0] wa,
                      input logic [31:0] alu, input logic [31:0] rd, input bit m2r,
                      input bit link, input logic [2:0] ld, input bit st, input bit fl);
        #1;
        bus.valid_m    = v;
        bus.instr_m    = v ? $urandom : 32'd0;
        bus.pc_m       = pc;
        bus.wr_m       = wr;
        bus.waddr_m    = wa;
        bus.alu_m      = alu;
        bus.dmem_rd    = rd;
        bus.mem_to_reg = m2r;
        bus.link_m     = link;
        bus.ld_type_m  = ld;
        bus.stall_w    = st;
        bus.flush_w    = fl;
        @(negedge clk);
    endtask

    task automatic idle();
        op(0, 32'd0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 3'd0, 0, 0);
    endtask

    typedef struct {
        logic [2:0]  ld;
        logic [31:0] alu;
        logic [31:0] exp;
        bit          mis;
    } ld_case_t;

    ld_case_t ld_cases[5];
    int       pulses;

    initial begin
        ld_cases[0] = '{ld: 3'd1, alu: 32'h100, exp: 32'hFFFF_FF80, mis: 0};
        ld_cases[1] = '{ld: 3'd2, alu: 32'h101, exp: 32'h0000_00FF, mis: 0};
        ld_cases[2] = '{ld: 3'd3, alu: 32'h102, exp: 32'h0000_7F01, mis: 0};
        ld_cases[3] = '{ld: 3'd4, alu: 32'h100, exp: 32'h0000_80FF, mis: 0};
        ld_cases[4] = '{ld: 3'd3, alu: 32'h101, exp: 32'h0000_0000, mis: 1};

        bus.valid_m = 0; bus.instr_m = 0; bus.pc_m = 0; bus.wr_m = 0; bus.waddr_m = 0;
        bus.alu_m = 0; bus.dmem_rd = 0; bus.mem_to_reg = 0; bus.link_m = 0;
        bus.ld_type_m = 0; bus.stall_w = 0; bus.flush_w = 0;

        // Reset state, checked mid-cycle while reset is held.
        #1 rst = 1'b1;
        #2;
        chk("rst pc_w", bus.pc_w, 32'h0000_3000);
        chk("rst instr_w", bus.instr_w, 32'd0);
        chk("rst gpr_wr", 32'(bus.gpr_wr), 32'd0);
        chk("rst retire_cnt", bus.retire_cnt, 32'd0);
        chk("rst misalign_w", 32'(bus.misalign_w), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Plain ALU writeback.
        op(1, 32'h3000, 1, 5'd8, 32'h1234, 32'd0, 0, 0, 3'd0, 0, 0);
        chk("alu gpr_wr", 32'(bus.gpr_wr), 32'd1);
        chk("alu waddr", 32'(bus.gpr_waddr), 32'd8);
        chk("alu wd", bus.gpr_wd, 32'h1234);
        idle();
        chk("alu retire_cnt", bus.retire_cnt, 32'd1);

        // Load lanes and extension.
        foreach (ld_cases[i]) begin
            op(1, 32'h3004, 1, 5'd9, ld_cases[i].alu, 32'h80FF_7F01, 1, 0, ld_cases[i].ld, 0, 0);
            chk("load misalign_w", 32'(bus.misalign_w), 32'(ld_cases[i].mis));
            chk("load gpr_wr", 32'(bus.gpr_wr), 32'(!ld_cases[i].mis));
            if (!ld_cases[i].mis) chk("load wd", bus.gpr_wd, ld_cases[i].exp);
        end
        idle();
        chk("load retire_cnt", bus.retire_cnt, 32'd6);

        // Link writes pc+8; $0 destination is dropped but still retires.
        op(1, 32'h3010, 1, 5'd31, 32'hABCD, 32'd0, 0, 1, 3'd0, 0, 0);
        chk("jal gpr_wr", 32'(bus.gpr_wr), 32'd1);
        chk("jal wd", bus.gpr_wd, 32'h3018);
        op(1, 32'h3010, 1, 5'd0, 32'hABCD, 32'd0, 0, 1, 3'd0, 0, 0);
        chk("jal $0 gpr_wr", 32'(bus.gpr_wr), 32'd0);
        idle();
        chk("jal retire_cnt", bus.retire_cnt, 32'd8);

        // Stall holds W; only one write and one retire.
        op(1, 32'h3020, 1, 5'd5, 32'h55, 32'd0, 0, 0, 3'd0, 0, 0);
        pulses = int'(bus.gpr_wr);
        for (int k = 0; k < 3; k++) begin
            op(1, 32'h3024, 1, 5'd6, 32'h66, 32'd0, 0, 0, 3'd0, 1, 0);
            pulses += int'(bus.gpr_wr);
            chk("stall pc_w", bus.pc_w, 32'h3020);
        end
        chk("stall pulses", 32'(pulses), 32'd1);
        idle();
        chk("stall retire_cnt", bus.retire_cnt, 32'd9);
        op(1, 32'h3028, 1, 5'd7, 32'h77, 32'd0, 0, 0, 3'd0, 0, 0);
        op(1, 32'h302C, 1, 5'd7, 32'h78, 32'd0, 0, 0, 3'd0, 1, 1);
        chk("flush instr_w", bus.instr_w, 32'd0);
        chk("flush gpr_wr", 32'(bus.gpr_wr), 32'd0);

        // Reset while an instruction is stalled in W.
        op(1, 32'h3030, 1, 5'd6, 32'h99, 32'd0, 0, 0, 3'd0, 0, 0);
        op(1, 32'h3034, 1, 5'd6, 32'h9A, 32'd0, 0, 0, 3'd0, 1, 0);
        #1 rst = 1'b1;
        #2;
        chk("mid rst pc_w", bus.pc_w, 32'h0000_3000);
        chk("mid rst gpr_wr", 32'(bus.gpr_wr), 32'd0);
        chk("mid rst retire_cnt", bus.retire_cnt, 32'd0);
        chk("mid rst instr_w", bus.instr_w, 32'd0);
        bus.valid_m = 0; bus.stall_w = 0;
        rst = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [2:0] ld;
            ld = 3'($urandom_range(0, 4));
            op(($urandom_range(0, 9) < 8), $urandom, $urandom_range(0, 3) != 0,
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
               $urandom, $urandom, $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0,
               ld, $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0);
        end
        idle();
        idle();

        // Counter wrap from all-ones.
        #1;
        force dut.cnt_q = 32'hFFFF_FFFF;
        cnt_off = 32'hFFFF_FFFF - retired;
        #1 release dut.cnt_q;
        @(negedge clk);
        op(1, 32'h3040, 1, 5'd3, 32'h33, 32'd0, 0, 0, 3'd0, 0, 0);
        chk("wrap pre retire_cnt", bus.retire_cnt, 32'hFFFF_FFFF);
        idle();
        chk("wrap retire_cnt", bus.retire_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
